// File: rtl/fir_coeff_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_pkg
// Purpose  : Shared sizes, error-bit indices and FSM encoding for the FIR
//            coefficient reload responder.
// Revision : 1.0 - initial release
// ============================================================================
package fir_coeff_pkg;

    localparam int NUM_LANES = 4;
    localparam int ADR_W     = 2;
    localparam int DATA_W    = 16;
    localparam int DEPTH     = 1 << ADR_W;

    // Sticky error flag positions in out_err
    localparam int ERR_WR_DURING_RD = 0;
    localparam int ERR_RD_DURING_RD = 1;
    localparam int ERR_ARESET_ABORT = 2;
    localparam int ERR_ADR_X        = 3;

    // FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

endpackage : fir_coeff_pkg
`default_nettype wire

// File: rtl/fir_coeff_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_if
// Purpose  : Coefficient reload bus between fir_coeff_master (initiator) and
//            fir_coeff_slave (responder).
// Revision : 1.0 - initial release
// ============================================================================
interface fir_coeff_if;
    import fir_coeff_pkg::*;

    logic                        coeff_in_areset;
    logic [NUM_LANES-1:0]        coeff_in_we;
    logic [ADR_W-1:0]            coeff_in_adr;
    logic [NUM_LANES*DATA_W-1:0] coeff_in_data;
    logic                        coeff_in_read;
    logic [NUM_LANES-1:0]        coeff_out_valid;
    logic [NUM_LANES*DATA_W-1:0] coeff_out_data;

    modport master (
        output coeff_in_areset, coeff_in_we, coeff_in_adr, coeff_in_data, coeff_in_read,
        input  coeff_out_valid, coeff_out_data
    );

    modport slave (
        input  coeff_in_areset, coeff_in_we, coeff_in_adr, coeff_in_data, coeff_in_read,
        output coeff_out_valid, coeff_out_data
    );

endinterface : fir_coeff_if
`default_nettype wire

// File: rtl/fir_coeff_lane_bank.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_lane_bank
// Purpose  : One lane's shadow/active coefficient storage. Writes land in the
//            shadow bank; commit copies the whole shadow bank into the active
//            bank in one edge; clear zeroes both.
// Revision : 1.0 - initial release
// ============================================================================
module fir_coeff_lane_bank
    import fir_coeff_pkg::*;
(
    input  wire logic                    clk,
    input  wire logic                    reset_n,
    input  wire logic                    i_clr,
    input  wire logic                    i_we,
    input  wire logic [ADR_W-1:0]        i_wr_adr,
    input  wire logic [DATA_W-1:0]       i_wr_data,
    input  wire logic                    i_commit,
    input  wire logic [ADR_W-1:0]        i_rd_adr,
    output logic      [DATA_W-1:0]       o_rd_data,
    output logic      [DEPTH*DATA_W-1:0] o_active
);

    logic [DATA_W-1:0] shadow_q [DEPTH];
    logic [DATA_W-1:0] shadow_d [DEPTH];
    logic [DATA_W-1:0] active_q [DEPTH];
    logic [DATA_W-1:0] active_d [DEPTH];

    // Next-state of both banks: clear wins, otherwise write into shadow and/or commit
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (i_clr) begin
            for (int a = 0; a < DEPTH; a++) begin
                shadow_d[a] = '0;
                active_d[a] = '0;
            end
        end else begin
            if (i_we) begin
                shadow_d[i_wr_adr] = i_wr_data;
            end
            if (i_commit) begin
                active_d = shadow_q;
            end
        end
    end

    // Bank storage with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                shadow_q[a] <= '0;
                active_q[a] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Read from the next-state active bank so a read launched on a commit
    // edge returns the freshly committed coefficients.
    always_comb begin
        o_rd_data = active_d[i_rd_adr];
        for (int a = 0; a < DEPTH; a++) begin
            o_active[a*DATA_W +: DATA_W] = active_q[a];
        end
    end

endmodule : fir_coeff_lane_bank
`default_nettype wire

// File: rtl/fir_coeff_slave.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_slave
// Purpose  : Responder for FIR coefficient reload. Accepts per-lane writes
//            into a shadow bank, commits atomically at end of burst, streams
//            the active bank on read and flags protocol misuse.
// Revision : 1.0 - initial release
// ============================================================================
module fir_coeff_slave
    import fir_coeff_pkg::*;
(
    input  wire logic                              clk,
    input  wire logic                              reset_n,
    fir_coeff_if.slave                             coeff,
    output logic [NUM_LANES*DEPTH*DATA_W-1:0]      coeff_active,
    output logic                                   coeff_update,
    output logic [7:0]                             out_err
);

    logic [0:0]                  state_q,   state_d;
    logic [ADR_W-1:0]            cnt_q,     cnt_d;
    logic                        pending_q, pending_d;
    logic [NUM_LANES-1:0]        valid_q,   valid_d;
    logic [NUM_LANES*DATA_W-1:0] data_q,    data_d;
    logic                        update_q,  update_d;
    logic [7:0]                  err_q,     err_d;

    logic                        w_clr;
    logic                        w_commit;
    logic [NUM_LANES-1:0]        w_we;
    logic [ADR_W-1:0]            w_rd_adr;
    logic [NUM_LANES*DATA_W-1:0] w_rd_data;

    // Control FSM: areset overrides everything; writes/commit only in IDLE;
    // READ streams one address per cycle until the counter wraps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        valid_d   = '0;
        update_d  = 1'b0;
        err_d     = err_q;
        w_clr     = 1'b0;
        w_commit  = 1'b0;
        w_we      = '0;
        w_rd_adr  = cnt_q;

        if (coeff.coeff_in_areset) begin
            w_clr     = 1'b1;
            pending_d = 1'b0;
            update_d  = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
            if (state_q == ST_READ) begin
                err_d[ERR_ARESET_ABORT] = 1'b1;
            end
        end else if (state_q == ST_IDLE) begin
            w_we = coeff.coeff_in_we;
            if (|coeff.coeff_in_we) begin
                pending_d = 1'b1;
`ifndef SYNTHESIS
                if ($isunknown(coeff.coeff_in_adr)) begin
                    err_d[ERR_ADR_X] = 1'b1;
                end
`endif
            end else if (pending_q) begin
                w_commit  = 1'b1;
                pending_d = 1'b0;
                update_d  = 1'b1;
            end
            if (coeff.coeff_in_read) begin
                state_d  = ST_READ;
                cnt_d    = ADR_W'(1);
                valid_d  = '1;
                w_rd_adr = '0;
            end
        end else begin
            if (|coeff.coeff_in_we) begin
                err_d[ERR_WR_DURING_RD] = 1'b1;
            end
            if (coeff.coeff_in_read) begin
                err_d[ERR_RD_DURING_RD] = 1'b1;
            end
            // Counter at zero means the last beat is on the bus: leave READ
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                valid_d = '1;
                cnt_d   = cnt_q + ADR_W'(1);
            end
        end
    end

    // Read beat data: zero whenever no beat is launched
    always_comb begin
        data_d = (|valid_d) ? w_rd_data : '0;
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            valid_q   <= '0;
            data_q    <= '0;
            update_q  <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            update_q  <= update_d;
            err_q     <= err_d;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        fir_coeff_lane_bank u_bank (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_clr     (w_clr),
            .i_we      (w_we[k]),
            .i_wr_adr  (coeff.coeff_in_adr),
            .i_wr_data (coeff.coeff_in_data[k*DATA_W +: DATA_W]),
            .i_commit  (w_commit),
            .i_rd_adr  (w_rd_adr),
            .o_rd_data (w_rd_data[k*DATA_W +: DATA_W]),
            .o_active  (coeff_active[k*DEPTH*DATA_W +: DEPTH*DATA_W])
        );
    end

    assign coeff.coeff_out_valid = valid_q;
    assign coeff.coeff_out_data  = data_q;
    assign coeff_update          = update_q;
    assign out_err               = err_q;

endmodule : fir_coeff_slave
`default_nettype wire

// File: tb/tb_fir_coeff_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_coeff_slave
// Purpose  : Self-checking bench for fir_coeff_slave: directed scenarios
//            with literal expectations, then randomized traffic checked every
//            cycle against a behavioural model of the coefficient banks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_coeff_slave;
    import fir_coeff_pkg::*;

    logic         clk;
    logic         reset_n;
    logic [255:0] coeff_active;
    logic         coeff_update;
    logic [7:0]   out_err;

    fir_coeff_if bus ();

    fir_coeff_slave dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .coeff        (bus),
        .coeff_active (coeff_active),
        .coeff_update (coeff_update),
        .out_err      (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] sh  [4][4];
    logic [15:0] act [4][4];
    bit          pend;
    logic [63:0] beats [$];
    bit          disp;
    logic [63:0] disp_data;
    bit          exp_upd;
    logic [7:0]  exp_err;
    bit          busy;

    function automatic logic [255:0] act_flat();
        logic [255:0] f;
        for (int l = 0; l < 4; l++)
            for (int a = 0; a < 4; a++)
                f[(l*4+a)*16 +: 16] = act[l][a];
        return f;
    endfunction

    task automatic clear_banks();
        for (int l = 0; l < 4; l++)
            for (int a = 0; a < 4; a++) begin
                sh[l][a]  = 16'h0;
                act[l][a] = 16'h0;
            end
        pend = 0;
    endtask

    // A read is "in progress" exactly while its beats are on the bus
    always @(posedge clk) begin
        busy    = disp;
        exp_upd = 0;
        if (!reset_n) begin
            clear_banks();
            exp_err = 8'h0;
            beats.delete();
            disp = 0;
        end else if (bus.coeff_in_areset) begin
            if (busy) exp_err[2] = 1'b1;
            clear_banks();
            exp_upd = 1;
            beats.delete();
            disp = 0;
        end else begin
            if (!busy) begin
                for (int l = 0; l < 4; l++)
                    if (bus.coeff_in_we[l])
                        sh[l][bus.coeff_in_adr] = bus.coeff_in_data[l*16 +: 16];
                if (bus.coeff_in_we != 4'h0) pend = 1;
                else if (pend) begin
                    act     = sh;
                    pend    = 0;
                    exp_upd = 1;
                end
                if (bus.coeff_in_read)
                    for (int a = 0; a < 4; a++)
                        beats.push_back({act[3][a], act[2][a], act[1][a], act[0][a]});
            end else begin
                if (bus.coeff_in_we != 4'h0) exp_err[0] = 1'b1;
                if (bus.coeff_in_read)       exp_err[1] = 1'b1;
            end
            if (beats.size() > 0) begin
                disp      = 1;
                disp_data = beats.pop_front();
            end else begin
                disp = 0;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("valid",  {252'h0, bus.coeff_out_valid}, disp ? 256'hF : 256'h0);
            if (disp) chk("rdata", {192'h0, bus.coeff_out_data}, {192'h0, disp_data});
            chk("active", coeff_active, act_flat());
            chk("update", {255'h0, coeff_update}, {255'h0, exp_upd});
            chk("err",    {248'h0, out_err}, {248'h0, exp_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.coeff_in_areset = 1'b0;
        bus.coeff_in_we     = 4'h0;
        bus.coeff_in_adr    = 2'h0;
        bus.coeff_in_data   = 64'h0;
        bus.coeff_in_read   = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        idle_in();
        reset_n = 1'b0;
        tick();
        check_en = 1;
        tick();
        reset_n = 1'b1;

        // Reset then idle
        tick();
        chk("rst_active", coeff_active, 256'h0);
        chk("rst_valid",  {252'h0, bus.coeff_out_valid}, 256'h0);
        chk("rst_err",    {248'h0, out_err}, 256'h0);
        repeat (3) tick();

        // Full write burst, active must stay untouched until commit
        for (int a = 0; a < 4; a++) begin
            bus.coeff_in_we  = 4'hF;
            bus.coeff_in_adr = 2'(a);
            for (int l = 0; l < 4; l++) d[l*16 +: 16] = 16'h1000 + 16'(4*a + l);
            bus.coeff_in_data = d;
            tick();
            chk("burst_upd",    {255'h0, coeff_update}, 256'h0);
            chk("burst_active", coeff_active, 256'h0);
        end
        idle_in();
        tick();
        chk("commit_upd", {255'h0, coeff_update}, 256'h1);
        chk("l2a3", {240'h0, coeff_active[176 +: 16]}, {240'h0, 16'h100E});
        tick();

        // Read after commit
        bus.coeff_in_read = 1'b1;
        tick();
        bus.coeff_in_read = 1'b0;
        tick();
        chk("beat1_valid", {252'h0, bus.coeff_out_valid}, 256'hF);
        chk("beat1_data",  {192'h0, bus.coeff_out_data}, {192'h0, 64'h1007_1006_1005_1004});
        repeat (3) tick();
        chk("post_read_valid", {252'h0, bus.coeff_out_valid}, 256'h0);
        tick();

        // Write and extra read while READ is active
        bus.coeff_in_read = 1'b1;
        tick();
        bus.coeff_in_read = 1'b0;
        tick();
        tick();
        bus.coeff_in_we   = 4'b0010;
        bus.coeff_in_adr  = 2'd2;
        bus.coeff_in_data = 64'h0000_0000_BEEF_0000;
        bus.coeff_in_read = 1'b1;
        tick();
        idle_in();
        chk("err_rw", {248'h0, out_err}, {248'h0, 8'h03});
        repeat (4) tick();
        chk("l1a2_kept", {240'h0, coeff_active[96 +: 16]}, {240'h0, 16'h1009});

        // Areset aborting a READ at beat 2
        bus.coeff_in_read = 1'b1;
        tick();
        bus.coeff_in_read = 1'b0;
        tick();
        tick();
        bus.coeff_in_areset = 1'b1;
        tick();
        bus.coeff_in_areset = 1'b0;
        chk("abort_valid",  {252'h0, bus.coeff_out_valid}, 256'h0);
        chk("abort_active", coeff_active, 256'h0);
        chk("abort_upd",    {255'h0, coeff_update}, 256'h1);
        chk("abort_err",    {248'h0, out_err}, {248'h0, 8'h07});
        bus.coeff_in_areset = 1'b1;
        tick();
        bus.coeff_in_areset = 1'b0;
        tick();
        chk("err_sticky", {248'h0, out_err}, {248'h0, 8'h07});

        // Single-lane write followed by read+commit on the same edge
        bus.coeff_in_we   = 4'b0100;
        bus.coeff_in_adr  = 2'd1;
        bus.coeff_in_data = 64'h0000_00AA_0000_0000;
        tick();
        idle_in();
        bus.coeff_in_read = 1'b1;
        tick();
        bus.coeff_in_read = 1'b0;
        tick();
        chk("same_edge_l2", {240'h0, bus.coeff_out_data[32 +: 16]}, {240'h0, 16'h00AA});
        repeat (4) tick();

        // reset_n is the only thing that clears out_err
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("err_cleared", {248'h0, out_err}, 256'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.coeff_in_areset = ($urandom_range(0, 99) < 3);
            bus.coeff_in_read   = ($urandom_range(0, 99) < 10);
            bus.coeff_in_we     = ($urandom_range(0, 99) < 35) ? 4'($urandom_range(1, 15)) : 4'h0;
            bus.coeff_in_adr    = 2'($urandom_range(0, 3));
            bus.coeff_in_data   = {$urandom, $urandom};
            reset_n             = ($urandom_range(0, 499) != 0);
            tick();
        end
        idle_in();
        reset_n = 1'b1;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fir_coeff_slave
`default_nettype wire
